// File: rtl/muldiv_sched.sv
// ============================================================================
// Module   : muldiv_sched
// Brief    : EX-stage mult/div sequencer owning HI/LO, with ID-stage stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  we,
    input  logic [1:0]  re,
    input  logic        md_use_ID,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int C_MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int C_CW   = $clog2(C_MAXC + 1);
    localparam logic [C_CW-1:0] C_MUL_N = C_CW'(MUL_CYCLES);
    localparam logic [C_CW-1:0] C_DIV_N = C_CW'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [C_CW-1:0]   r_cnt;
    logic [31:0]       r_hi, r_lo, r_phi, r_plo;
    logic              r_pvalid;
    logic              w_commit;

    // ---------------- arithmetic ----------------
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_a_neg, w_b_neg, w_bzero;
    logic [31:0]        w_abs_a, w_abs_b, w_den_u, w_den_s;
    logic [31:0]        w_qu, w_ru, w_qm, w_rm, w_qs, w_rs;
    logic [31:0]        w_res_hi, w_res_lo;

    assign w_prod_s = 64'($signed(A)) * 64'($signed(B));
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed division via magnitudes sidesteps the 0x80000000 / -1 overflow.
    assign w_a_neg  = A[31];
    assign w_b_neg  = B[31];
    assign w_bzero  = (B == 32'd0);
    assign w_abs_a  = w_a_neg ? (32'd0 - A) : A;
    assign w_abs_b  = w_b_neg ? (32'd0 - B) : B;
    assign w_den_u  = w_bzero ? 32'd1 : B;
    assign w_den_s  = w_bzero ? 32'd1 : w_abs_b;
    assign w_qu     = A / w_den_u;
    assign w_ru     = A % w_den_u;
    assign w_qm     = w_abs_a / w_den_s;
    assign w_rm     = w_abs_a % w_den_s;
    assign w_qs     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_qm) : w_qm;
    assign w_rs     = w_a_neg ? (32'd0 - w_rm) : w_rm;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (op)
            2'b00:   begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
            2'b01:   begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
            2'b10:   begin w_res_hi = w_rs;            w_res_lo = w_qs;           end
            default: begin w_res_hi = w_ru;            w_res_lo = w_qu;           end
        endcase
    end

    // ---------------- control ----------------
    assign w_commit = (r_state == S_RUN) && (r_cnt == C_CW'(1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)    w_next_state = S_RUN;
            S_RUN:   if (w_commit) w_next_state = S_IDLE;
            default:               w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_phi    <= 32'd0;
            r_plo    <= 32'd0;
            r_pvalid <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_phi    <= w_res_hi;
                r_plo    <= w_res_lo;
                r_pvalid <= !(op[1] && w_bzero);
                r_cnt    <= op[1] ? C_DIV_N : C_MUL_N;
            end else if (we == 2'b01) begin
                r_lo <= A;
            end else if (we == 2'b10) begin
                r_hi <= A;
            end
        end else begin
            r_cnt <= r_cnt - C_CW'(1);
            if (w_commit && r_pvalid) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end
    end

    assign busy  = (r_state == S_RUN);
    assign stall = md_use_ID & (start | busy);
    assign HI    = r_hi;
    assign LO    = r_lo;
    assign rdata = (re == 2'b01) ? r_lo : (re == 2'b10) ? r_hi : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sched.sv
// ============================================================================
// Module   : tb_muldiv_sched
// Brief    : Directed vector bench for muldiv_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [1:0]  we = 2'b00;
    logic [1:0]  re = 2'b00;
    logic        md_use_ID = 1'b0;
    logic [31:0] rdata;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_err = 0;

    muldiv_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .we(we), .re(re), .md_use_ID(md_use_ID), .rdata(rdata),
        .busy(busy), .stall(stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t vecs[10];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mt(input logic [1:0] w, input logic [31:0] d);
        we = w; A = d;
        tick;
        we = 2'b00; A = 32'd0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        tick;
        start = 1'b0; A = 32'd0; B = 32'd0;
    endtask

    // Waits out the busy window, checking committed HI/LO hold and stall each cycle.
    task automatic wait_idle(input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                             input logic exp_stall, output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            chk("hold_HI", HI, hold_hi);
            chk("hold_LO", LO, hold_lo);
            chk("busy_stall", {31'd0, stall}, {31'd0, exp_stall});
            tick;
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{2'b11, 32'd7,        32'd0,        32'h5A5A5A5A, 32'hA5A5A5A5, 10};
        vecs[4] = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[8] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[9] = '{2'b10, 32'd5,        32'd0,        32'h5A5A5A5A, 32'hA5A5A5A5, 10};

        tick; tick;
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            mt(2'b01, 32'hA5A5A5A5);
            mt(2'b10, 32'h5A5A5A5A);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(32'h5A5A5A5A, 32'hA5A5A5A5, 1'b0, n);
            chk($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].n));
            chk($sformatf("v%0d_HI", i), HI, vecs[i].hi);
            chk($sformatf("v%0d_LO", i), LO, vecs[i].lo);
            re = 2'b10; #1;
            chk($sformatf("v%0d_rd_hi", i), rdata, vecs[i].hi);
            re = 2'b01; #1;
            chk($sformatf("v%0d_rd_lo", i), rdata, vecs[i].lo);
            re = 2'b00;
        end

        // re values other than 01/10 read as zero; we=11 writes nothing
        re = 2'b11; #1;
        chk("rd_none", rdata, 32'd0);
        re = 2'b00;
        mt(2'b01, 32'h00000011);
        mt(2'b10, 32'h00000022);
        mt(2'b11, 32'hDEADBEEF);
        chk("we11_HI", HI, 32'h22);
        chk("we11_LO", LO, 32'h11);

        // mthi and a second start while busy are ignored
        mt(2'b01, 32'h77);
        mt(2'b10, 32'h66);
        issue(2'b00, 32'd3, 32'd4);
        chk("ign_c1", HI, 32'h66);
        tick;
        we = 2'b10; A = 32'h1234;
        tick;
        we = 2'b00;
        start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd5;
        tick;
        start = 1'b0; A = 32'd0; B = 32'd0;
        wait_idle(32'h66, 32'h77, 1'b0, n);
        chk("ign_rest_cycles", 32'(n), 32'd2);
        chk("ign_HI", HI, 32'd0);
        chk("ign_LO", LO, 32'd12);
        mt(2'b10, 32'h1234);
        chk("idle_mthi", HI, 32'h1234);

        // start wins over a same-cycle write
        start = 1'b1; op = 2'b01; A = 32'd2; B = 32'd3; we = 2'b01;
        tick;
        start = 1'b0; we = 2'b00; A = 32'd0; B = 32'd0;
        wait_idle(32'h1234, 32'd12, 1'b0, n);
        chk("prio_HI", HI, 32'd0);
        chk("prio_LO", LO, 32'd6);

        // stall covers issue cycle plus all busy cycles
        md_use_ID = 1'b1; #1;
        chk("stall_idle", {31'd0, stall}, 32'd0);
        start = 1'b1; op = 2'b00; A = 32'd1; B = 32'd1; #1;
        chk("stall_issue", {31'd0, stall}, 32'd1);
        tick;
        start = 1'b0;
        wait_idle(32'd0, 32'd6, 1'b1, n);
        chk("stall_cycles", 32'(n), 32'd5);
        chk("stall_drop", {31'd0, stall}, 32'd0);
        md_use_ID = 1'b0;
        start = 1'b1; op = 2'b11; A = 32'd9; B = 32'd2; #1;
        chk("nostall_issue", {31'd0, stall}, 32'd0);
        tick;
        start = 1'b0;
        wait_idle(32'd0, 32'd1, 1'b0, n);
        chk("nostall_HI", HI, 32'd1);
        chk("nostall_LO", LO, 32'd4);

        // reset mid-divide discards the pending result
        mt(2'b01, 32'h11);
        mt(2'b10, 32'h22);
        issue(2'b10, 32'd100, 32'd3);
        tick; tick; tick;
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_HI", HI, 32'd0);
        chk("rst_mid_LO", LO, 32'd0);
        repeat (12) tick;
        chk("rst_late_busy", {31'd0, busy}, 32'd0);
        chk("rst_late_HI", HI, 32'd0);
        chk("rst_late_LO", LO, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
